execute_stage: RTL and testbench

- Pipeline EX stage, sitting directly upstream of the memory-access stage.
- Consumes decoded operands and the instruction word from the ID stage. Produces the registered HI, LO, Z (ALU result / effective address), Rt (store data) and IR values that the memory-access stage takes as its inputs ex_HI, ex_LO, ex_Z, ex_Rt and ex_IR.
- Single-cycle ALU ops pass straight through; MULT/MULTU/DIV/DIVU/MUL run on an iterative multi-cycle unit, and the stage requests a pipeline stall while that unit is working.

---
 rtl/execute_stage.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Pipeline EX stage: single-cycle ALU plus a radix-2 iterative multiply/divide
// unit that raises busy to hold the pipeline while it iterates.
module execute_stage #(
    parameter int MD_CYCLES = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] id_A,
    input  logic [DATA_W-1:0] id_B,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_IR,
    input  logic [1:0]        cond,
    output logic [DATA_W-1:0] rHI,
    output logic [DATA_W-1:0] rLO,
    output logic [DATA_W-1:0] rZ,
    output logic [DATA_W-1:0] rRt,
    output logic [DATA_W-1:0] rIR,
    output logic              busy
);

    localparam logic [1:0]        COND_FLOW  = 2'd0;
    localparam logic [1:0]        COND_STALL = 2'd1;
    localparam logic [1:0]        COND_ZERO  = 2'd2;
    localparam logic [DATA_W-1:0] IR_NON     = '0;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_LHU      = 6'h25;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_MUL   = 6'h02;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam int               CNT_W    = $clog2(MD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_d;
    logic [CNT_W-1:0] cnt;

    logic [5:0] opc, fn;
    logic [4:0] shamt;
    logic [DATA_W-1:0] imm_z;
    logic is_mult, is_div, is_mul, md_op, md_signed;
    logic a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    logic [DATA_W-1:0] alu_z, alu_hi, alu_lo;

    // Iteration state: {md_hi, md_lo} is the product accumulator for multiply,
    // and remainder/dividend-becoming-quotient for divide.
    logic [DATA_W-1:0] md_hi, md_lo, md_b, md_a;
    logic md_neg_q, md_neg_r, md_div, md_mul, md_div0;
    logic md_start, md_step;

    logic [DATA_W-1:0] mul_add, step_hi, step_lo, div_rem;
    logic [DATA_W:0]   mul_sum, div_sh;
    logic              div_ok;
    logic [2*DATA_W-1:0] prod_mag, prod;
    logic [DATA_W-1:0] quot, rem;

    logic ld_out;
    logic [DATA_W-1:0] nxt_hi, nxt_lo, nxt_z, nxt_rt, nxt_ir;

    assign opc   = id_IR[31:26];
    assign fn    = id_IR[5:0];
    assign shamt = id_IR[10:6];
    assign imm_z = {{(DATA_W-16){1'b0}}, id_imm[15:0]};

    assign is_mult   = (opc == OP_SPECIAL) && (fn == F_MULT || fn == F_MULTU);
    assign is_div    = (opc == OP_SPECIAL) && (fn == F_DIV || fn == F_DIVU);
    assign is_mul    = (opc == OP_SPECIAL2) && (fn == F_MUL);
    assign md_op     = is_mult || is_div || is_mul;
    assign md_signed = is_mul || ((opc == OP_SPECIAL) && (fn == F_MULT || fn == F_DIV));

    // Signed ops iterate on magnitudes; the sign is reapplied to the result.
    assign a_neg = md_signed && id_A[DATA_W-1];
    assign b_neg = md_signed && id_B[DATA_W-1];
    assign a_mag = a_neg ? -id_A : id_A;
    assign b_mag = b_neg ? -id_B : id_B;

    assign busy = ((state == S_IDLE) && md_op && (cond == COND_FLOW)) || (state == S_RUN);

    always_comb begin
        alu_z  = '0;
        alu_hi = '0;
        alu_lo = '0;
        if (opc == OP_SPECIAL) begin
            case (fn)
                F_SLL:          alu_z = id_B << shamt;
                F_SRL:          alu_z = id_B >> shamt;
                F_SRA:          alu_z = $signed(id_B) >>> shamt;
                F_SLLV:         alu_z = id_B << id_A[4:0];
                F_SRLV:         alu_z = id_B >> id_A[4:0];
                F_SRAV:         alu_z = $signed(id_B) >>> id_A[4:0];
                F_MFHI, F_MFLO: alu_z = id_B;
                F_MTHI:         alu_hi = id_A;
                F_MTLO:         alu_lo = id_A;
                F_ADD, F_ADDU:  alu_z = id_A + id_B;
                F_SUB, F_SUBU:  alu_z = id_A - id_B;
                F_AND:          alu_z = id_A & id_B;
                F_OR:           alu_z = id_A | id_B;
                F_XOR:          alu_z = id_A ^ id_B;
                F_NOR:          alu_z = ~(id_A | id_B);
                F_SLT:          alu_z = DATA_W'($signed(id_A) < $signed(id_B));
                F_SLTU:         alu_z = DATA_W'(id_A < id_B);
                default:        ;
            endcase
        end else begin
            case (opc)
                OP_ADDI, OP_ADDIU: alu_z = id_A + id_imm;
                OP_SLTI:           alu_z = DATA_W'($signed(id_A) < $signed(id_imm));
                OP_SLTIU:          alu_z = DATA_W'(id_A < id_imm);
                OP_ANDI:           alu_z = id_A & imm_z;
                OP_ORI:            alu_z = id_A | imm_z;
                OP_XORI:           alu_z = id_A ^ imm_z;
                OP_LUI:            alu_z = {id_imm[15:0], {(DATA_W-16){1'b0}}};
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                OP_SB, OP_SH, OP_SW: alu_z = id_A + id_imm;
                default:           ;
            endcase
        end
    end

    assign mul_add = md_lo[0] ? md_b : '0;
    assign mul_sum = {1'b0, md_hi} + {1'b0, mul_add};
    assign div_sh  = {md_hi, md_lo[DATA_W-1]};
    assign div_ok  = div_sh >= {1'b0, md_b};
    assign div_rem = DATA_W'(div_sh - {1'b0, md_b});

    always_comb begin
        if (md_div) begin
            step_hi = div_ok ? div_rem : div_sh[DATA_W-1:0];
            step_lo = {md_lo[DATA_W-2:0], div_ok};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], md_lo[DATA_W-1:1]};
        end
    end

    assign prod_mag = {md_hi, md_lo};
    assign prod     = md_neg_q ? -prod_mag : prod_mag;
    assign quot     = md_div0 ? '1 : (md_neg_q ? -md_lo : md_lo);
    assign rem      = md_div0 ? md_a : (md_neg_r ? -md_hi : md_hi);

    always_comb begin
        state_d  = state;
        ld_out   = 1'b1;
        md_start = 1'b0;
        md_step  = 1'b0;
        nxt_hi   = '0;
        nxt_lo   = '0;
        nxt_z    = '0;
        nxt_rt   = '0;
        nxt_ir   = IR_NON;
        case (state)
            S_IDLE: begin
                if (cond == COND_FLOW) begin
                    if (md_op) begin
                        md_start = 1'b1;
                        state_d  = S_RUN;
                    end else begin
                        nxt_hi = alu_hi;
                        nxt_lo = alu_lo;
                        nxt_z  = alu_z;
                        nxt_rt = id_B;
                        nxt_ir = id_IR;
                    end
                end else if (cond == COND_STALL) begin
                    ld_out = 1'b0;
                end
            end
            S_RUN: begin
                if (cond == COND_ZERO) begin
                    state_d = S_IDLE;
                end else begin
                    md_step = 1'b1;
                    if (cnt == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cond == COND_FLOW) begin
                    if (md_mul) begin
                        nxt_z = prod[DATA_W-1:0];
                    end else if (md_div) begin
                        nxt_hi = rem;
                        nxt_lo = quot;
                    end else begin
                        nxt_hi = prod[2*DATA_W-1:DATA_W];
                        nxt_lo = prod[DATA_W-1:0];
                    end
                    nxt_rt  = id_B;
                    nxt_ir  = id_IR;
                    state_d = S_IDLE;
                end else if (cond == COND_STALL) begin
                    ld_out = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_b     <= '0;
            md_a     <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_div   <= 1'b0;
            md_mul   <= 1'b0;
            md_div0  <= 1'b0;
        end else if (md_start) begin
            cnt      <= '0;
            md_hi    <= '0;
            md_lo    <= a_mag;
            md_b     <= b_mag;
            md_a     <= id_A;
            md_neg_q <= a_neg ^ b_neg;
            md_neg_r <= a_neg;
            md_div   <= is_div;
            md_mul   <= is_mul;
            md_div0  <= is_div && (id_B == '0);
        end else if (md_step) begin
            cnt   <= cnt + CNT_W'(1);
            md_hi <= step_hi;
            md_lo <= step_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rHI <= '0;
            rLO <= '0;
            rZ  <= '0;
            rRt <= '0;
            rIR <= IR_NON;
        end else if (ld_out) begin
            rHI <= nxt_hi;
            rLO <= nxt_lo;
            rZ  <= nxt_z;
            rRt <= nxt_rt;
            rIR <= nxt_ir;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized bench for execute_stage against a behavioural ALU / mul-div model.
module tb_execute_stage;

    localparam int          MD_CYCLES = 32;
    localparam logic [1:0]  C_FLOW    = 2'd0;
    localparam logic [1:0]  C_STALL   = 2'd1;
    localparam logic [1:0]  C_ZERO    = 2'd2;
    localparam logic [31:0] IR_NON    = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_A, id_B, id_imm, id_IR;
    logic [1:0]  cond;
    logic [31:0] rHI, rLO, rZ, rRt, rIR;
    logic        busy;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] e_hi, e_lo, e_z, e_rt, e_ir;

    logic [5:0] R_FN [22] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11,
                              6'h12, 6'h13, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
    logic [5:0] I_OP [17] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F};

    execute_stage #(.MD_CYCLES(MD_CYCLES), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_A(id_A), .id_B(id_B), .id_imm(id_imm), .id_IR(id_IR), .cond(cond),
        .rHI(rHI), .rLO(rLO), .rZ(rZ), .rRt(rRt), .rIR(rIR), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rt(input logic [5:0] f, input logic [4:0] sh);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] im);
        return {op, 5'd1, 5'd2, im};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic alu_ref(input logic [31:0] ir, a, b, imm,
                           output logic [31:0] z, hi, lo);
        int sh;
        logic [31:0] iz;
        sh = int'(ir[10:6]);
        iz = {16'h0, imm[15:0]};
        z = 0; hi = 0; lo = 0;
        if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                6'h00: z = b << sh;
                6'h02: z = b >> sh;
                6'h03: z = int'(b) >>> sh;
                6'h04: z = b << int'(a[4:0]);
                6'h06: z = b >> int'(a[4:0]);
                6'h07: z = int'(b) >>> int'(a[4:0]);
                6'h10, 6'h12: z = b;
                6'h11: hi = a;
                6'h13: lo = a;
                6'h20, 6'h21: z = a + b;
                6'h22, 6'h23: z = a - b;
                6'h24: z = a & b;
                6'h25: z = a | b;
                6'h26: z = a ^ b;
                6'h27: z = ~(a | b);
                6'h2A: z = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                6'h2B: z = (a < b) ? 32'd1 : 32'd0;
                default: ;
            endcase
        end else begin
            case (ir[31:26])
                6'h08, 6'h09: z = a + imm;
                6'h0A: z = (int'(a) < int'(imm)) ? 32'd1 : 32'd0;
                6'h0B: z = (a < imm) ? 32'd1 : 32'd0;
                6'h0C: z = a & iz;
                6'h0D: z = a | iz;
                6'h0E: z = a ^ iz;
                6'h0F: z = {imm[15:0], 16'h0};
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: z = a + imm;
                default: ;
            endcase
        end
    endtask

    task automatic md_ref(input logic [31:0] ir, a, b, output logic [31:0] z, hi, lo);
        logic signed [63:0] sp;
        logic [63:0] up;
        z = 0; hi = 0; lo = 0;
        sp = longint'(int'(a)) * longint'(int'(b));
        up = {32'h0, a} * {32'h0, b};
        if (ir[31:26] == 6'h1C) begin
            z = sp[31:0];
        end else begin
            case (ir[5:0])
                6'h18: {hi, lo} = sp;
                6'h19: {hi, lo} = up;
                6'h1A: begin
                    if (b == 0) begin
                        lo = 32'hFFFF_FFFF; hi = a;
                    end else begin
                        sp = longint'(int'(a)) / longint'(int'(b));
                        lo = sp[31:0];
                        sp = longint'(int'(a)) % longint'(int'(b));
                        hi = sp[31:0];
                    end
                end
                6'h1B: begin
                    if (b == 0) begin
                        lo = 32'hFFFF_FFFF; hi = a;
                    end else begin
                        lo = a / b; hi = a % b;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".hi"}, rHI, e_hi);
        chk({tag, ".lo"}, rLO, e_lo);
        chk({tag, ".z"},  rZ,  e_z);
        chk({tag, ".rt"}, rRt, e_rt);
        chk({tag, ".ir"}, rIR, e_ir);
    endtask

    task automatic alu_dir(input string tag, input logic [31:0] ir, a, b, imm, exp_z);
        id_IR = ir; id_A = a; id_B = b; id_imm = imm; cond = C_FLOW;
        tick();
        chk({tag, ".z"}, rZ, exp_z);
        chk({tag, ".ir"}, rIR, ir);
    endtask

    task automatic run_md(input string tag, input logic [31:0] ir, a, b);
        int n;
        int bad;
        id_IR = ir; id_A = a; id_B = b; id_imm = 32'h0; cond = C_FLOW;
        n = 0; bad = 0;
        #1;
        while (busy && n < 100) begin
            tick();
            n++;
            if (rIR !== IR_NON) bad++;
        end
        chk({tag, ".busy_cycles"}, n, MD_CYCLES + 1);
        chk({tag, ".bubble"}, bad, 0);
        tick();
        md_ref(ir, a, b, e_z, e_hi, e_lo);
        e_rt = b; e_ir = ir;
        chk_out(tag);
    endtask

    initial begin
        logic [31:0] MULT_W, MULTU_W, DIV_W, DIVU_W, MUL_W, ADDU_W;
        int n;
        int bad;
        MULT_W  = rt(6'h18, 5'd0);
        MULTU_W = rt(6'h19, 5'd0);
        DIV_W   = rt(6'h1A, 5'd0);
        DIVU_W  = rt(6'h1B, 5'd0);
        ADDU_W  = rt(6'h21, 5'd0);
        MUL_W   = {6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02};

        // Reset with garbage inputs
        rst = 1'b0;
        id_A = $urandom; id_B = $urandom; id_imm = $urandom; id_IR = $urandom;
        cond = 2'($urandom_range(0, 3));
        tick();
        tick();
        rst = 1'b1;
        id_A = 0; id_B = 0; id_imm = 0; id_IR = IR_NON; cond = C_FLOW;
        #1;
        e_hi = 0; e_lo = 0; e_z = 0; e_rt = 0; e_ir = IR_NON;
        chk_out("reset");
        chk("reset.busy", busy, 0);

        // Random ALU ops with mixed FLOW / STALL / ZERO
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ir, a, b, im, z, hi, lo;
            int c;
            a = rnd32(); b = rnd32(); im = rnd32();
            if ($urandom_range(0, 1) == 1)
                ir = rt(R_FN[$urandom_range(0, 21)], 5'($urandom_range(0, 31)));
            else
                ir = it(I_OP[$urandom_range(0, 16)], im[15:0]);
            c = int'($urandom_range(0, 9));
            id_IR = ir; id_A = a; id_B = b; id_imm = im;
            cond = (c < 7) ? C_FLOW : ((c < 9) ? C_STALL : C_ZERO);
            if (cond == C_FLOW) begin
                alu_ref(ir, a, b, im, z, hi, lo);
                e_z = z; e_hi = hi; e_lo = lo; e_rt = b; e_ir = ir;
            end else if (cond == C_ZERO) begin
                e_z = 0; e_hi = 0; e_lo = 0; e_rt = 0; e_ir = IR_NON;
            end
            #1;
            chk($sformatf("alu%0d.busy", i), busy, 0);
            tick();
            chk_out($sformatf("alu%0d", i));
        end

        // Directed ALU boundaries
        alu_dir("addu_wrap", ADDU_W, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        alu_dir("slt_neg", rt(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1);
        alu_dir("sltu_big", rt(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        alu_dir("sra4", rt(6'h03, 5'd4), 32'h0, 32'h8000_0000, 32'h0, 32'hF800_0000);

        // Directed multiply / divide
        run_md("mult_neg", MULT_W, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg.const", {rHI, rLO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_md("div_neg", DIV_W, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg.const", {rHI, rLO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("div_zero", DIV_W, 32'd5, 32'd0);
        chk("div_zero.const", {rHI, rLO}, 64'h0000_0005_FFFF_FFFF);
        run_md("div_ovf", DIV_W, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf.const", {rHI, rLO}, 64'h0000_0000_8000_0000);
        run_md("mul_lo", MUL_W, 32'hFFFF_FFF9, 32'd6);
        chk("mul_lo.const", rZ, 32'hFFFF_FFD6);

        // Random back-to-back multiply / divide
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ir, a, b;
            case ($urandom_range(0, 4))
                0:       ir = MULT_W;
                1:       ir = MULTU_W;
                2:       ir = DIV_W;
                3:       ir = DIVU_W;
                default: ir = MUL_W;
            endcase
            a = rnd32(); b = rnd32();
            if ($urandom_range(0, 5) == 0) b = 0;
            run_md($sformatf("md%0d", i), ir, a, b);
        end

        // COND_ZERO aborts an iteration in progress
        id_IR = MULT_W; id_A = 32'd9; id_B = 32'd9; cond = C_FLOW;
        tick();
        repeat (10) tick();
        cond = C_ZERO;
        #1;
        chk("abort.busy_run", busy, 1);
        tick();
        chk("abort.busy_drop", busy, 0);
        chk("abort.ir", rIR, IR_NON);
        chk("abort.hi", rHI, 0);
        id_IR = ADDU_W; id_A = 32'd5; id_B = 32'd7; cond = C_FLOW;
        #1;
        chk("abort.addu_busy", busy, 0);
        tick();
        chk("abort.addu_z", rZ, 32'd12);
        chk("abort.addu_ir", rIR, ADDU_W);

        // STALL while DONE holds the bubble, then emits on FLOW
        id_IR = DIVU_W; id_A = 32'd100; id_B = 32'd7; cond = C_FLOW;
        n = 0;
        #1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("stall.busy_cycles", n, MD_CYCLES + 1);
        cond = C_STALL;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d.ir", k), rIR, IR_NON);
            chk($sformatf("stall%0d.lo", k), rLO, 0);
            chk($sformatf("stall%0d.busy", k), busy, 0);
        end
        cond = C_FLOW;
        tick();
        chk("stall.lo", rLO, 32'd14);
        chk("stall.hi", rHI, 32'd2);
        chk("stall.ir", rIR, DIVU_W);

        // Reset mid-iteration: nothing is emitted afterwards
        id_IR = MULT_W; id_A = 32'd6; id_B = 32'd7; cond = C_FLOW;
        tick();
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        id_IR = IR_NON; id_A = 0; id_B = 0; id_imm = 0; cond = C_FLOW;
        #1;
        e_hi = 0; e_lo = 0; e_z = 0; e_rt = 0; e_ir = IR_NON;
        chk_out("rstrun");
        chk("rstrun.busy", busy, 0);
        bad = 0;
        repeat (40) begin
            tick();
            if ((rHI | rLO | rZ | rIR) != 0) bad++;
        end
        chk("rstrun.no_result", bad, 0);
        run_md("post_rst", MULTU_W, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
